// File: rtl/bcd_sum_display.sv
// Scanned three-digit 7-segment driver for a 9-bit BCD sum {hundreds, tens, units}.
// Captures a sum on sum_valid, then multiplexes the held value onto a shared segment
// bus with active-low digit enables. Nibbles above 9 show as 'E' and raise err.
// Optional feature: define LEADING_ZERO_BLANK_EN to blank leading zero digits.
module bcd_sum_display #(
  parameter int unsigned SCAN_DIV = 50000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sum_valid,
  input  logic [8:0] sum,
  output logic [6:0] seg,
  output logic [2:0] dig,
  output logic       err
);

  localparam int unsigned PcW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PcW-1:0] PcMax = PcW'(SCAN_DIV - 1);

  // Digit index states
  localparam logic [1:0] IDX_UNITS = 2'd0;
  localparam logic [1:0] IDX_TENS  = 2'd1;
  localparam logic [1:0] IDX_HUND  = 2'd2;

  logic [8:0]     val_q, val_d;
  logic [PcW-1:0] pc_q, pc_d;
  logic [1:0]     idx_q, idx_d;
  logic [6:0]     seg_q, seg_d;
  logic [2:0]     dig_q, dig_d;
  logic           err_q, err_d;

  logic       pc_wrap;
  logic [3:0] nib;
  logic [2:0] dig_sel;
  logic       blank;

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h3F;
      4'd1:    s = 7'h06;
      4'd2:    s = 7'h5B;
      4'd3:    s = 7'h4F;
      4'd4:    s = 7'h66;
      4'd5:    s = 7'h6D;
      4'd6:    s = 7'h7D;
      4'd7:    s = 7'h07;
      4'd8:    s = 7'h7F;
      4'd9:    s = 7'h6F;
      default: s = 7'h79; // 'E' for 10..15
    endcase
    return s;
  endfunction

  // Prescaler, digit index and held value next-state
  always_comb begin
    pc_wrap = (pc_q == PcMax);
    pc_d    = pc_wrap ? '0 : pc_q + 1'b1;
    idx_d   = idx_q;
    if (pc_wrap) begin
      case (idx_q)
        IDX_UNITS: idx_d = IDX_TENS;
        IDX_TENS:  idx_d = IDX_HUND;
        default:   idx_d = IDX_UNITS;
      endcase
    end
    // No back-pressure: the latest strobe simply overwrites the held value
    val_d = sum_valid ? sum : val_q;
  end

  // Output decode from the current index and held value (registered below)
  always_comb begin
    case (idx_q)
      IDX_TENS: begin
        nib     = val_q[7:4];
        dig_sel = 3'b101;
      end
      IDX_HUND: begin
        nib     = {3'b000, val_q[8]};
        dig_sel = 3'b011;
      end
      default: begin
        nib     = val_q[3:0];
        dig_sel = 3'b110;
      end
    endcase

`ifdef LEADING_ZERO_BLANK_EN
    // Only literal zeros are blanked, so an 'E' nibble is always shown
    case (idx_q)
      IDX_TENS: blank = !val_q[8] && (val_q[7:4] == 4'd0);
      IDX_HUND: blank = !val_q[8];
      default:  blank = 1'b0;
    endcase
`else
    blank = 1'b0;
`endif

    seg_d = blank ? 7'h00 : seg_decode(nib);
    dig_d = blank ? 3'b111 : dig_sel;
    err_d = (val_q[3:0] > 4'd9) | (val_q[7:4] > 4'd9);
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      val_q <= '0;
      pc_q  <= '0;
      idx_q <= IDX_UNITS;
      seg_q <= 7'h00;
      dig_q <= 3'b111;
      err_q <= 1'b0;
    end else begin
      val_q <= val_d;
      pc_q  <= pc_d;
      idx_q <= idx_d;
      seg_q <= seg_d;
      dig_q <= dig_d;
      err_q <= err_d;
    end
  end

  assign seg = seg_q;
  assign dig = dig_q;
  assign err = err_q;

endmodule

// File: tb/tb_bcd_sum_display.sv
// Scoreboard bench for bcd_sum_display: a reference model pushes the expected
// {seg, dig, err} for every clock edge; a negedge monitor pops and compares.
module tb_bcd_sum_display;

  localparam int unsigned SD = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       sum_valid;
  logic [8:0] sum;
  logic [6:0] seg;
  logic [2:0] dig;
  logic       err;

  int tests  = 0;
  int fails  = 0;
  int cyc_no = 0;

  logic [10:0] exp_q[$];

  bcd_sum_display #(.SCAN_DIV(SD)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .sum_valid (sum_valid),
    .sum       (sum),
    .seg       (seg),
    .dig       (dig),
    .err       (err)
  );

  always #5 clk = ~clk;

  // Reference model: slot derived from edge count since reset, digit by arithmetic
  int         seg_tab[16] = '{'h3F, 'h06, 'h5B, 'h4F, 'h66, 'h6D, 'h7D, 'h07,
                              'h7F, 'h6F, 'h79, 'h79, 'h79, 'h79, 'h79, 'h79};
  int         m_val     = 0;
  int         m_n       = 0;
  bit         m_started = 0;

  always @(posedge clk) begin
    int slot, d;
    bit blank;
    logic [6:0] e_seg;
    logic [2:0] e_dig;
    logic       e_err;
    if (!rst_n) begin
      m_started = 1;
      m_val     = 0;
      m_n       = 0;
      exp_q.push_back({7'h00, 3'b111, 1'b0});
    end else if (m_started) begin
      slot = (m_n / SD) % 3;
      if (slot == 0)      d = m_val % 16;
      else if (slot == 1) d = (m_val / 16) % 16;
      else                d = m_val / 256;
      blank = 0;
`ifdef LEADING_ZERO_BLANK_EN
      if (slot == 2 && m_val < 256) blank = 1;
      if (slot == 1 && m_val < 16)  blank = 1;
`endif
      e_seg = blank ? 7'h00 : 7'(seg_tab[d]);
      e_dig = blank ? 3'b111 : ~(3'b001 << slot);
      e_err = ((m_val % 16) > 9) || (((m_val / 16) % 16) > 9);
      exp_q.push_back({e_seg, e_dig, e_err});
      m_n++;
      if (sum_valid) m_val = int'(sum);
    end
  end

  // Monitor: compares once per cycle, away from the active edge
  always @(negedge clk) begin
    logic [10:0] e;
    cyc_no++;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      tests++;
      if ({seg, dig, err} !== e) begin
        fails++;
        $display("FAIL out@cycle%0d: got seg=%h dig=%b err=%b, expected seg=%h dig=%b err=%b",
                 cyc_no, seg, dig, err, e[10:4], e[3:1], e[0]);
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic capture(input logic [8:0] v);
    sum_valid = 1'b1;
    sum       = v;
    @(negedge clk);
    sum_valid = 1'b0;
  endtask

  initial begin
    logic [8:0] r;
    rst_n     = 1'b0;
    sum_valid = 1'b0;
    sum       = '0;
    idle(3);
    rst_n = 1'b1;
    idle(2 * 3 * SD);

    // Mid-slot capture, then walk a full frame
    idle(2);
    capture(9'h157);
    idle(3 * SD + 1);

    // Invalid tens nibble, then recovery
    capture(9'h0A3);
    idle(3 * SD + 1);
    capture(9'h023);
    idle(3 * SD + 1);

    // Leading zeros
    capture(9'h005);
    idle(3 * SD + 1);
    capture(9'h040);
    idle(3 * SD + 1);

    // Reset coincident with a capture strobe
    rst_n     = 1'b0;
    sum_valid = 1'b1;
    sum       = 9'h199;
    @(negedge clk);
    rst_n     = 1'b1;
    sum_valid = 1'b0;
    idle(3 * SD + 1);

    // Back-to-back captures
    capture(9'h011);
    capture(9'h122);
    idle(3 * SD + 1);

    // Randomised captures, occasional resets
    for (int i = 0; i < 400; i++) begin
      r = 9'($urandom);
      if ($urandom_range(0, 3) != 0)
        r = {1'($urandom_range(0, 1)), 4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
      sum       = r;
      sum_valid = ($urandom_range(0, 5) == 0);
      rst_n     = ($urandom_range(0, 79) != 0);
      @(negedge clk);
    end
    sum_valid = 1'b0;
    rst_n     = 1'b1;
    idle(3);

    tests++;
    if (tests < 400) begin
      fails++;
      $display("FAIL scoreboard_count: got %0d comparisons, expected at least 400", tests);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
